// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control sequencer.
// Contents: opcode/funct encodings, FSM state enum, and the select codes driven
// onto the datapath muxes (ALU op, PC source, register destination, writeback
// source, ALU B operand) plus the halt error codes.
package mips_ctrl_pkg;

    // Instruction encodings (IR[31:26] and IR[5:0]).
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_PRINT = 6'b111111;
    localparam logic [5:0] FN_JR    = 6'b001000;

    // ALU operation select.
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // PC source select.
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_REGA   = 2'b11;

    // Register-file destination select.
    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;

    // Register-file writeback source select.
    localparam logic [1:0] WB_ALUOUT = 2'b00;
    localparam logic [1:0] WB_MDR    = 2'b01;
    localparam logic [1:0] WB_LUI    = 2'b10;
    localparam logic [1:0] WB_PC     = 2'b11;

    // ALU B operand select.
    localparam logic [1:0] ALUB_REGB    = 2'b00;
    localparam logic [1:0] ALUB_FOUR    = 2'b01;
    localparam logic [1:0] ALUB_IMM     = 2'b10;
    localparam logic [1:0] ALUB_IMM_SH2 = 2'b11;

    // Halt cause reported on error_code.
    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    typedef enum logic [4:0] {
        S_IDLE, S_FETCH, S_DECODE,
        S_REXEC, S_RWB, S_IEXEC, S_IWB,
        S_MADDR, S_MREAD, S_MWB, S_MWRITE,
        S_BRANCH, S_JUMP, S_JAL, S_JR, S_LUI,
        S_PRINT, S_HALT
    } state_t;

    // States that sit waiting on an external ready handshake.
    function automatic logic is_wait_state(input state_t s);
        return (s == S_FETCH) || (s == S_MREAD) || (s == S_MWRITE) || (s == S_PRINT);
    endfunction

endpackage

// File: rtl/ctrl_wait_timer.sv
// Handshake wait timer.
// Counts cycles spent waiting for a ready that has not arrived. The count
// returns to zero whenever the sequencer is outside a wait state or the
// awaited handshake completes, so every entry into a wait state starts at 0.
// Ports:
//   clk, rst_n  clock and synchronous active-low reset
//   i_clear     force the count to zero (not in a wait state)
//   i_enable    sequencer is in a wait state this cycle
//   i_ready     the awaited ready is high this cycle
//   o_timeout   this is the TIMEOUT_CYCLES-th consecutive cycle without ready
module ctrl_wait_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    input  logic i_ready,
    output logic o_timeout
);

    localparam logic [15:0] LAST_WAIT = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clear || (i_enable && i_ready)) begin
            r_cnt <= '0;
        end else if (i_enable) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    // A ready arriving on the final allowed cycle still wins.
    assign o_timeout = i_enable && !i_ready && (r_cnt == LAST_WAIT);

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle MIPS control sequencer.
// Walks each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the
// datapath mux selects and write enables. Memory and print handshakes are
// guarded by a wait timer; an illegal opcode or an expired wait parks the
// sequencer in HALT until reset. Retired instructions are counted (wrapping).
// Ports:
//   clk, rst_n          clock and synchronous active-low reset
//   opcode, funct       IR[31:26] and IR[5:0], stable after the IR load
//   mem_ready           memory completes the requested access this cycle
//   print_ready         print sink accepts the offered value this cycle
//   pc_write*, pc_source, i_or_d, mem_read, mem_write, ir_write, reg_dst,
//   mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, print_valid
//                       per-cycle datapath controls
//   halted, error_code  sticky halt flag and its cause
//   retired             completed-instruction count
module multicycle_ctrl_fsm
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             mem_ready,
    input  logic             print_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             pc_write_cond_ne,
    output logic [1:0]       pc_source,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic [1:0]       reg_dst,
    output logic [1:0]       mem_to_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             print_valid,
    output logic             halted,
    output logic [1:0]       error_code,
    output logic [CNT_W-1:0] retired
);

    state_t           r_state;
    state_t           w_next_state;
    logic [1:0]       r_err;
    logic [1:0]       w_err_next;
    logic [CNT_W-1:0] r_retired;
    logic             w_retire;
    logic             w_wait;
    logic             w_ready;
    logic             w_timeout;

    assign w_wait  = is_wait_state(r_state);
    assign w_ready = (r_state == S_PRINT) ? print_ready : mem_ready;

    ctrl_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (!w_wait),
        .i_enable (w_wait),
        .i_ready  (w_ready),
        .o_timeout(w_timeout)
    );

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of process ordering.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_err     <= ERR_NONE;
            r_retired <= '0;
        end else begin
            r_state <= w_next_state;
            r_err   <= w_err_next;
            if (w_retire) begin
                r_retired <= r_retired + CNT_W'(1);
            end
        end
    end

    assign halted     = (r_state == S_HALT);
    assign error_code = r_err;
    assign retired    = r_retired;

    always_comb begin
        // NOTE: every output and next-state signal gets a default first, so
        // no path through the case below can leave one unassigned (no latch).
        w_next_state     = r_state;
        w_err_next       = r_err;
        w_retire         = 1'b0;
        pc_write         = 1'b0;
        pc_write_cond    = 1'b0;
        pc_write_cond_ne = 1'b0;
        pc_source        = PCSRC_ALU;
        i_or_d           = 1'b0;
        mem_read         = 1'b0;
        mem_write        = 1'b0;
        ir_write         = 1'b0;
        reg_dst          = REGDST_RT;
        mem_to_reg       = WB_ALUOUT;
        reg_write        = 1'b0;
        alu_src_a        = 1'b0;
        alu_src_b        = ALUB_REGB;
        alu_op           = ALUOP_ADD;
        print_valid      = 1'b0;

        case (r_state)
            S_IDLE: w_next_state = S_FETCH;

            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = ALUB_FOUR;
                // PC+4 and the IR load only commit when the fetch completes.
                if (mem_ready) begin
                    ir_write     = 1'b1;
                    pc_write     = 1'b1;
                    w_next_state = S_DECODE;
                end else if (w_timeout) begin
                    w_next_state = S_HALT;
                    w_err_next   = ERR_TIMEOUT;
                end
            end

            S_DECODE: begin
                alu_src_b = ALUB_IMM_SH2;
                case (opcode)
                    OP_RTYPE:      w_next_state = (funct == FN_JR) ? S_JR : S_REXEC;
                    OP_ADDI:       w_next_state = S_IEXEC;
                    OP_LW, OP_SW:  w_next_state = S_MADDR;
                    OP_BEQ, OP_BNE: w_next_state = S_BRANCH;
                    OP_J:          w_next_state = S_JUMP;
                    OP_JAL:        w_next_state = S_JAL;
                    OP_LUI:        w_next_state = S_LUI;
                    OP_PRINT:      w_next_state = S_PRINT;
                    default: begin
                        w_next_state = S_HALT;
                        w_err_next   = ERR_ILLEGAL;
                    end
                endcase
            end

            S_REXEC: begin
                alu_src_a    = 1'b1;
                alu_op       = ALUOP_FUNCT;
                w_next_state = S_RWB;
            end

            S_IEXEC, S_MADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = ALUB_IMM;
                // opcode still comes from the held IR, so it selects lw vs sw here.
                if (r_state == S_IEXEC) begin
                    w_next_state = S_IWB;
                end else begin
                    w_next_state = (opcode == OP_SW) ? S_MWRITE : S_MREAD;
                end
            end

            S_MREAD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready) begin
                    w_next_state = S_MWB;
                end else if (w_timeout) begin
                    w_next_state = S_HALT;
                    w_err_next   = ERR_TIMEOUT;
                end
            end

            S_MWRITE: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (mem_ready) begin
                    w_next_state = S_FETCH;
                    w_retire     = 1'b1;
                end else if (w_timeout) begin
                    w_next_state = S_HALT;
                    w_err_next   = ERR_TIMEOUT;
                end
            end

            S_PRINT: begin
                // Reg A stays selected, so the offered value is stable while waiting.
                print_valid = 1'b1;
                if (print_ready) begin
                    w_next_state = S_FETCH;
                    w_retire     = 1'b1;
                end else if (w_timeout) begin
                    w_next_state = S_HALT;
                    w_err_next   = ERR_TIMEOUT;
                end
            end

            S_RWB, S_IWB, S_MWB, S_BRANCH, S_JUMP, S_JAL, S_JR, S_LUI: begin
                w_next_state = S_FETCH;
                w_retire     = 1'b1;
                case (r_state)
                    S_RWB: begin
                        reg_dst   = REGDST_RD;
                        reg_write = 1'b1;
                    end
                    S_IWB: reg_write = 1'b1;
                    S_MWB: begin
                        mem_to_reg = WB_MDR;
                        reg_write  = 1'b1;
                    end
                    S_BRANCH: begin
                        alu_src_a        = 1'b1;
                        alu_op           = ALUOP_SUB;
                        pc_source        = PCSRC_ALUOUT;
                        pc_write_cond    = (opcode == OP_BEQ);
                        pc_write_cond_ne = (opcode == OP_BNE);
                    end
                    S_JUMP: begin
                        pc_write  = 1'b1;
                        pc_source = PCSRC_JUMP;
                    end
                    S_JAL: begin
                        pc_write   = 1'b1;
                        pc_source  = PCSRC_JUMP;
                        reg_write  = 1'b1;
                        reg_dst    = REGDST_RA;
                        mem_to_reg = WB_PC;
                    end
                    S_JR: begin
                        pc_write  = 1'b1;
                        pc_source = PCSRC_REGA;
                    end
                    default: begin
                        // S_LUI
                        reg_write  = 1'b1;
                        mem_to_reg = WB_LUI;
                    end
                endcase
            end

            S_HALT: w_next_state = S_HALT;

            default: w_next_state = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench for multicycle_ctrl_fsm.
// The driver walks whole instructions and, for each cycle it drives, pushes
// the control word that instruction class must show in that cycle. A monitor
// pops one word per cycle on the falling edge and compares it with the DUT.
module tb_multicycle_ctrl_fsm;

    localparam int TO = 6;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       mem_ready;
    logic       print_ready;
    logic       pc_write, pc_write_cond, pc_write_cond_ne;
    logic [1:0] pc_source;
    logic       i_or_d, mem_read, mem_write, ir_write;
    logic [1:0] reg_dst, mem_to_reg;
    logic       reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op;
    logic       print_valid, halted;
    logic [1:0] error_code;
    logic [7:0] retired;

    always #5 clk = ~clk;

    multicycle_ctrl_fsm #(
        .TIMEOUT_CYCLES(TO),
        .CNT_W         (8)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .opcode          (opcode),
        .funct           (funct),
        .mem_ready       (mem_ready),
        .print_ready     (print_ready),
        .pc_write        (pc_write),
        .pc_write_cond   (pc_write_cond),
        .pc_write_cond_ne(pc_write_cond_ne),
        .pc_source       (pc_source),
        .i_or_d          (i_or_d),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .ir_write        (ir_write),
        .reg_dst         (reg_dst),
        .mem_to_reg      (mem_to_reg),
        .reg_write       (reg_write),
        .alu_src_a       (alu_src_a),
        .alu_src_b       (alu_src_b),
        .alu_op          (alu_op),
        .print_valid     (print_valid),
        .halted          (halted),
        .error_code      (error_code),
        .retired         (retired)
    );

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       pc_write_cond_ne;
        logic [1:0] pc_source;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       print_valid;
        logic       halted;
        logic [1:0] error_code;
        logic [7:0] retired;
    } ctl_t;

    typedef struct {
        ctl_t  v;
        string tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_ret  = 0;
    ctl_t act;

    logic [5:0] ops [10] = '{6'b000000, 6'b001000, 6'b100011, 6'b101011, 6'b000100,
                             6'b000101, 6'b000010, 6'b000011, 6'b001111, 6'b111111};

    assign act = {pc_write, pc_write_cond, pc_write_cond_ne, pc_source, i_or_d, mem_read,
                  mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
                  alu_op, print_valid, halted, error_code, retired};

    // Monitor: one expected control word per driven cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (act !== e.v) begin
                    n_fail++;
                    $display("FAIL %s: got ctl=%h retired=%0d, expected ctl=%h retired=%0d",
                             e.tag, act, act.retired, e.v, e.v.retired);
                end
            end
        end
    end

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic ctl_t base();
        ctl_t c = '0;
        c.retired = 8'(exp_ret);
        return c;
    endfunction

    task automatic retire();
        exp_ret = (exp_ret + 1) % 256;
    endtask

    // Drive one cycle's ready inputs and record what the DUT must show in it.
    task automatic cycle(input logic mr, input logic pr, input ctl_t v, input string tag);
        exp_t e;
        mem_ready   = mr;
        print_ready = pr;
        e.v   = v;
        e.tag = tag;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input ctl_t cur, input string tag);
        rst_n = 1'b0;
        cycle(rnd(), rnd(), cur, tag);
        rst_n   = 1'b1;
        exp_ret = 0;
        cycle(rnd(), rnd(), base(), "idle_after_reset");
    endtask

    task automatic halt_and_reset(input logic [1:0] err, input string tag);
        ctl_t h;
        h = base();
        h.halted     = 1'b1;
        h.error_code = err;
        for (int i = 0; i < 3; i++) cycle(rnd(), rnd(), h, tag);
        do_reset(h, tag);
    endtask

    // A handshake phase: `delay` cycles without ready, then the ready cycle,
    // unless the wait budget of TO cycles runs out first.
    task automatic wait_phase(input ctl_t w, input ctl_t wr, input int delay, input bit use_pr,
                              input bit term, input string tag, output bit to);
        int n;
        n  = (delay < TO) ? delay : TO;
        to = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (use_pr) cycle(rnd(), 1'b0, w, tag);
            else        cycle(1'b0, rnd(), w, tag);
        end
        if (delay >= TO) begin
            to = 1'b1;
        end else begin
            if (use_pr) cycle(rnd(), 1'b1, wr, tag);
            else        cycle(1'b1, rnd(), wr, tag);
            if (term) retire();
        end
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int fd,
                             input int md, input int pd, input int abort_mread);
        ctl_t c, cr;
        bit   to;
        opcode = op;
        funct  = fn;

        c = base();
        c.mem_read  = 1'b1;
        c.alu_src_b = 2'b01;
        cr = c;
        cr.ir_write = 1'b1;
        cr.pc_write = 1'b1;
        wait_phase(c, cr, fd, 1'b0, 1'b0, "fetch", to);
        if (to) begin
            halt_and_reset(2'b10, "fetch_timeout_halt");
            return;
        end

        c = base();
        c.alu_src_b = 2'b11;
        cycle(rnd(), rnd(), c, "decode");

        c = base();
        case (op)
            6'b000000: begin
                if (fn == 6'b001000) begin
                    c.pc_write  = 1'b1;
                    c.pc_source = 2'b11;
                    cycle(rnd(), rnd(), c, "jr");
                end else begin
                    c.alu_src_a = 1'b1;
                    c.alu_op    = 2'b10;
                    cycle(rnd(), rnd(), c, "rexec");
                    c = base();
                    c.reg_dst   = 2'b01;
                    c.reg_write = 1'b1;
                    cycle(rnd(), rnd(), c, "rwb");
                end
                retire();
            end
            6'b001000, 6'b100011, 6'b101011: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
                cycle(rnd(), rnd(), c, (op == 6'b001000) ? "iexec" : "maddr");
                c = base();
                if (op == 6'b001000) begin
                    c.reg_write = 1'b1;
                    cycle(rnd(), rnd(), c, "iwb");
                    retire();
                end else if (op == 6'b101011) begin
                    c.mem_write = 1'b1;
                    c.i_or_d    = 1'b1;
                    wait_phase(c, c, md, 1'b0, 1'b1, "mwrite", to);
                    if (to) halt_and_reset(2'b10, "mwrite_timeout_halt");
                end else begin
                    c.mem_read = 1'b1;
                    c.i_or_d   = 1'b1;
                    if (abort_mread >= 0) begin
                        for (int i = 0; i < abort_mread; i++) cycle(1'b0, rnd(), c, "mread");
                        do_reset(c, "reset_mid_mread");
                        return;
                    end
                    wait_phase(c, c, md, 1'b0, 1'b0, "mread", to);
                    if (to) begin
                        halt_and_reset(2'b10, "mread_timeout_halt");
                        return;
                    end
                    c = base();
                    c.mem_to_reg = 2'b01;
                    c.reg_write  = 1'b1;
                    cycle(rnd(), rnd(), c, "mwb");
                    retire();
                end
            end
            6'b000100, 6'b000101: begin
                c.alu_src_a        = 1'b1;
                c.alu_op           = 2'b01;
                c.pc_source        = 2'b01;
                c.pc_write_cond    = (op == 6'b000100);
                c.pc_write_cond_ne = (op == 6'b000101);
                cycle(rnd(), rnd(), c, "branch");
                retire();
            end
            6'b000010, 6'b000011: begin
                c.pc_write  = 1'b1;
                c.pc_source = 2'b10;
                if (op == 6'b000011) begin
                    c.reg_write  = 1'b1;
                    c.reg_dst    = 2'b10;
                    c.mem_to_reg = 2'b11;
                end
                cycle(rnd(), rnd(), c, (op == 6'b000011) ? "jal" : "jump");
                retire();
            end
            6'b001111: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 2'b10;
                cycle(rnd(), rnd(), c, "lui");
                retire();
            end
            6'b111111: begin
                c.print_valid = 1'b1;
                wait_phase(c, c, pd, 1'b1, 1'b1, "print", to);
                if (to) halt_and_reset(2'b10, "print_timeout_halt");
            end
            default: halt_and_reset(2'b01, "illegal_halt");
        endcase
    endtask

    initial begin
        int         idx;
        logic [5:0] fn;
        rst_n       = 1'b0;
        mem_ready   = 1'b0;
        print_ready = 1'b0;
        opcode      = '0;
        funct       = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle(rnd(), rnd(), base(), "reset_idle");

        // Directed instruction classes and handshake boundaries.
        run_instr(6'b000000, 6'b100000, 0, 0, 0, -1);      // add
        run_instr(6'b100011, 6'b000000, 0, 3, 0, -1);      // lw, 3 stall cycles
        run_instr(6'b000011, 6'b010000, 0, 0, 0, -1);      // jal
        run_instr(6'b111111, 6'b000000, 0, 0, 5, -1);      // print, 5 stall cycles
        run_instr(6'b101011, 6'b000000, 1, 2, 0, -1);      // sw
        run_instr(6'b000100, 6'b000000, 0, 0, 0, -1);      // beq
        run_instr(6'b000101, 6'b000000, 2, 0, 0, -1);      // bne
        run_instr(6'b000010, 6'b000000, 0, 0, 0, -1);      // j
        run_instr(6'b001111, 6'b000000, 0, 0, 0, -1);      // lui
        run_instr(6'b000000, 6'b001000, 0, 0, 0, -1);      // jr
        run_instr(6'b001000, 6'b000000, TO - 1, 0, 0, -1); // ready on last allowed fetch cycle
        run_instr(6'b100011, 6'b000000, 0, TO - 1, 0, -1); // ready on last allowed mread cycle
        run_instr(6'b111111, 6'b000000, 0, 0, TO - 1, -1); // ready on last allowed print cycle
        run_instr(6'b001000, 6'b000000, TO, 0, 0, -1);     // fetch timeout
        run_instr(6'b000000, 6'b100010, 0, 0, 0, -1);
        run_instr(6'b100011, 6'b000000, 0, TO, 0, -1);     // mread timeout
        run_instr(6'b001111, 6'b000000, 0, 0, 0, -1);
        run_instr(6'b010101, 6'b000000, 0, 0, 0, -1);      // illegal opcode
        run_instr(6'b000011, 6'b000000, 0, 0, 0, -1);
        run_instr(6'b100011, 6'b000000, 0, 0, 0, 2);       // reset mid-MREAD
        run_instr(6'b001000, 6'b000000, 0, 0, 0, -1);

        // Random legal traffic; long enough for the 8-bit counter to wrap.
        for (int k = 0; k < 320; k++) begin
            idx = int'($urandom_range(0, 9));
            fn  = 6'($urandom);
            if (idx == 0 && $urandom_range(0, 2) == 0) fn = 6'b001000;
            run_instr(ops[idx], fn, int'($urandom_range(0, TO - 1)),
                      int'($urandom_range(0, TO - 1)), int'($urandom_range(0, TO - 1)), -1);
        end

        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected words left unchecked, required 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
